// File: rtl/crossbar_one_hot_pipe.sv
// crossbar_one_hot_pipe
//   One-hot routed crossbar with a persistent command register, a single
//   input capture stage, a conflict-detecting column mux and PIPE_DEPTH
//   output register stages. All stages advance together on i_en.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous reset, active low
//   i_valid     : per-input-lane valid            [NUM_INPUT_DATA]
//   i_data_bus  : input lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_en        : global advance; low holds every stage
//   i_cmd       : routing map, bit [i*NUM_OUTPUT_DATA+j] = input i -> output j
//   i_cmd_load  : load i_cmd into the command register (ignores i_en)
//   i_err_clr   : clear sticky conflict flags
//   o_valid     : per-output-lane valid           [NUM_OUTPUT_DATA]
//   o_data_bus  : output lanes, packed like the inputs
//   o_conflict  : sticky per-output conflict flags
module crossbar_one_hot_pipe #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_INPUT_DATA  = 8,
  parameter int unsigned NUM_OUTPUT_DATA = 8,
  parameter int unsigned PIPE_DEPTH      = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_DATA-1:0]             i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_data_bus,
  input  logic                                  i_en,
  input  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd,
  input  logic                                  i_cmd_load,
  input  logic                                  i_err_clr,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_OUTPUT_DATA-1:0]            o_conflict
);

  localparam int unsigned CMD_W  = NUM_INPUT_DATA * NUM_OUTPUT_DATA;
  localparam int unsigned IDAT_W = NUM_INPUT_DATA * DATA_WIDTH;
  localparam int unsigned ODAT_W = NUM_OUTPUT_DATA * DATA_WIDTH;

  // Command register and effective command
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] eff_cmd;

  // A command loaded this cycle already steers the beat presented with it.
  assign eff_cmd = i_cmd_load ? i_cmd : cmd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q <= '0;
    end else if (i_cmd_load) begin
      cmd_q <= i_cmd;
    end
  end

  // Stage 0: input capture
  logic [NUM_INPUT_DATA-1:0] s0_valid_q;
  logic [IDAT_W-1:0]         s0_data_q;
  logic [CMD_W-1:0]          s0_cmd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_valid_q <= '0;
      s0_data_q  <= '0;
      s0_cmd_q   <= '0;
    end else if (i_en) begin
      s0_valid_q <= i_valid;
      s0_data_q  <= i_data_bus;
      s0_cmd_q   <= eff_cmd;
    end
  end

  // Column mux
  // The per-column population count is reduced to "at least one" and
  // "more than one": with a single hit the OR of the masked sources equals
  // the selected source, and with several hits the lane is forced to zero.
  logic [NUM_OUTPUT_DATA-1:0] mux_valid;
  logic [ODAT_W-1:0]          mux_data;
  logic [NUM_OUTPUT_DATA-1:0] conf_hit;
  logic                       col_one;
  logic                       col_multi;
  logic                       col_v;
  logic [DATA_WIDTH-1:0]      col_d;

  always_comb begin
    mux_valid = '0;
    mux_data  = '0;
    conf_hit  = '0;
    col_one   = 1'b0;
    col_multi = 1'b0;
    col_v     = 1'b0;
    col_d     = '0;
    for (int unsigned j = 0; j < NUM_OUTPUT_DATA; j++) begin
      col_one   = 1'b0;
      col_multi = 1'b0;
      col_v     = 1'b0;
      col_d     = '0;
      for (int unsigned i = 0; i < NUM_INPUT_DATA; i++) begin
        if (s0_cmd_q[i*NUM_OUTPUT_DATA + j]) begin
          col_multi = col_multi | col_one;
          col_one   = 1'b1;
          col_v     = col_v | s0_valid_q[i];
          col_d     = col_d | s0_data_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // In a conflicting column col_v is the OR of all contributing valids.
      conf_hit[j]                        = col_multi & col_v;
      mux_valid[j]                       = col_v & ~col_multi;
      mux_data[j*DATA_WIDTH +: DATA_WIDTH] = col_multi ? '0 : col_d;
    end
  end

  // Output pipeline
  logic [NUM_OUTPUT_DATA-1:0] pv_q [PIPE_DEPTH];
  logic [ODAT_W-1:0]          pd_q [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
        pv_q[s] <= '0;
        pd_q[s] <= '0;
      end
    end else if (i_en) begin
      pv_q[0] <= mux_valid;
      pd_q[0] <= mux_data;
      for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
        pv_q[s] <= pv_q[s-1];
        pd_q[s] <= pd_q[s-1];
      end
    end
  end

  // Sticky conflict flags
  logic [NUM_OUTPUT_DATA-1:0] conflict_q;
  logic [NUM_OUTPUT_DATA-1:0] conflict_d;

  // Clear is applied first so a set on the same edge survives for its bit.
  always_comb begin
    conflict_d = i_err_clr ? '0 : conflict_q;
    if (i_en) begin
      conflict_d = conflict_d | conf_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign o_valid    = pv_q[PIPE_DEPTH-1];
  assign o_data_bus = pd_q[PIPE_DEPTH-1];
  assign o_conflict = conflict_q;

endmodule

// File: tb/tb_crossbar_one_hot_pipe.sv
// tb_crossbar_one_hot_pipe
//   Directed bench for crossbar_one_hot_pipe: one instance at default
//   parameters and one at DATA_WIDTH=7, 5 inputs, 3 outputs, PIPE_DEPTH=1.
module tb_crossbar_one_hot_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic         rst;
  logic [7:0]   i_valid;
  logic [255:0] i_data_bus;
  logic         i_en;
  logic [63:0]  i_cmd;
  logic         i_cmd_load;
  logic         i_err_clr;
  logic [7:0]   o_valid;
  logic [255:0] o_data_bus;
  logic [7:0]   o_conflict;

  // Odd-parameter instance
  logic [4:0]   i_valid_odd;
  logic [34:0]  i_data_odd;
  logic [14:0]  i_cmd_odd;
  logic         i_cmd_load_odd;
  logic [2:0]   o_valid_odd;
  logic [20:0]  o_data_odd;
  logic [2:0]   o_conflict_odd;

  int n_checks = 0;
  int n_errors = 0;

  crossbar_one_hot_pipe #(
    .DATA_WIDTH     (32),
    .NUM_INPUT_DATA (8),
    .NUM_OUTPUT_DATA(8),
    .PIPE_DEPTH     (3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .i_en      (i_en),
    .i_cmd     (i_cmd),
    .i_cmd_load(i_cmd_load),
    .i_err_clr (i_err_clr),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .o_conflict(o_conflict)
  );

  crossbar_one_hot_pipe #(
    .DATA_WIDTH     (7),
    .NUM_INPUT_DATA (5),
    .NUM_OUTPUT_DATA(3),
    .PIPE_DEPTH     (1)
  ) u_dut_odd (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid_odd),
    .i_data_bus(i_data_odd),
    .i_en      (i_en),
    .i_cmd     (i_cmd_odd),
    .i_cmd_load(i_cmd_load_odd),
    .i_err_clr (i_err_clr),
    .o_valid   (o_valid_odd),
    .o_data_bus(o_data_odd),
    .o_conflict(o_conflict_odd)
  );

  task automatic check_eq(input string tag, input logic [255:0] got,
                          input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ident_cmd();
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[i*8 + i] = 1'b1;
    return c;
  endfunction

  task automatic idle_inputs();
    i_valid    = '0;
    i_data_bus = '0;
    i_cmd_load = 1'b0;
  endtask

  logic [255:0] exp_bus;

  initial begin
    rst            = 1'b0;
    i_en           = 1'b0;
    i_cmd          = '0;
    i_err_clr      = 1'b0;
    i_valid_odd    = '0;
    i_data_odd     = '0;
    i_cmd_odd      = '0;
    i_cmd_load_odd = 1'b0;
    idle_inputs();

    // Reset state
    tick();
    tick();
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_data", o_data_bus, 0);
    check_eq("rst_conflict", o_conflict, 0);
    check_eq("rst_odd_valid", o_valid_odd, 0);
    rst = 1'b1;

    // Identity route, latency 4
    i_en       = 1'b1;
    i_cmd      = ident_cmd();
    i_cmd_load = 1'b1;
    i_valid    = 8'hFF;
    exp_bus    = '0;
    for (int i = 0; i < 8; i++) begin
      i_data_bus[i*32 +: 32] = 32'h100 + i;
      exp_bus[i*32 +: 32]    = 32'h100 + i;
    end
    tick();
    idle_inputs();
    tick();
    tick();
    check_eq("ident_early", o_valid, 0);
    tick();
    check_eq("ident_valid", o_valid, 8'hFF);
    check_eq("ident_data", o_data_bus, exp_bus);
    tick();
    check_eq("ident_bubble", o_valid, 0);

    // Multicast input 2 to all outputs
    i_cmd      = 64'h0000_0000_00FF_0000;
    i_cmd_load = 1'b1;
    i_valid    = 8'h04;
    i_data_bus[2*32 +: 32] = 32'hDEADBEEF;
    i_data_bus[0 +: 32]    = 32'h12345678;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    check_eq("mcast_valid", o_valid, 8'hFF);
    check_eq("mcast_data", o_data_bus, {8{32'hDEADBEEF}});
    check_eq("mcast_conflict", o_conflict, 0);

    // Conflict: inputs 0 and 1 on output 3, input 5 straight through
    i_cmd      = 64'h0000_2000_0000_0808;
    i_cmd_load = 1'b1;
    i_valid    = 8'h23;
    i_data_bus[0*32 +: 32] = 32'hA;
    i_data_bus[1*32 +: 32] = 32'hB;
    i_data_bus[5*32 +: 32] = 32'h55;
    tick();
    idle_inputs();
    tick();
    check_eq("conf_set", o_conflict, 8'h08);
    tick();
    tick();
    check_eq("conf_out_valid", o_valid, 8'h20);
    check_eq("conf_out_data", o_data_bus, 256'h55 << 160);
    check_eq("conf_sticky", o_conflict, 8'h08);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check_eq("conf_clr", o_conflict, 0);
    tick();
    tick();
    check_eq("conf_invalid_no_set", o_conflict, 0);
    i_valid = 8'h03;
    tick();
    i_valid   = '0;
    i_err_clr = 1'b1;
    tick();
    check_eq("conf_set_wins", o_conflict, 8'h08);
    tick();
    i_err_clr = 1'b0;
    check_eq("conf_clr2", o_conflict, 0);

    // Stall: beats 1..6 on lane 0, 5-cycle stall after beat 5 enters
    for (int k = 1; k <= 5; k++) begin
      i_cmd      = ident_cmd();
      i_cmd_load = (k == 1);
      i_valid    = 8'h01;
      i_data_bus = 256'(k);
      tick();
    end
    check_eq("stall_pre_valid", o_valid, 8'h01);
    check_eq("stall_pre_data", o_data_bus, 256'd2);
    i_en       = 1'b0;
    i_cmd_load = 1'b0;
    i_valid    = 8'hFF;
    i_data_bus = {8{32'h99}};
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_hold_valid", o_valid, 8'h01);
      check_eq("stall_hold_data", o_data_bus, 256'd2);
    end
    i_en       = 1'b1;
    i_valid    = 8'h01;
    i_data_bus = 256'd6;
    tick();
    check_eq("stall_seq3", o_data_bus, 256'd3);
    idle_inputs();
    for (int k = 4; k <= 6; k++) begin
      tick();
      check_eq("stall_seq_valid", o_valid, 8'h01);
      check_eq("stall_seq_data", o_data_bus, 256'(k));
    end
    tick();
    check_eq("stall_drain", o_valid, 0);

    // Command change: beat N-1 on identity, beat N loads input0->output1
    i_valid    = 8'h01;
    i_data_bus = 256'h11;
    tick();
    i_cmd      = 64'h2;
    i_cmd_load = 1'b1;
    i_data_bus = 256'h22;
    tick();
    i_cmd_load = 1'b0;
    i_data_bus = 256'h33;
    tick();
    idle_inputs();
    tick();
    check_eq("cmdchg_old_valid", o_valid, 8'h01);
    check_eq("cmdchg_old_data", o_data_bus, 256'h11);
    tick();
    check_eq("cmdchg_new_valid", o_valid, 8'h02);
    check_eq("cmdchg_new_data", o_data_bus, 256'h22 << 32);
    tick();
    check_eq("cmdchg_kept_valid", o_valid, 8'h02);
    check_eq("cmdchg_kept_data", o_data_bus, 256'h33 << 32);

    // Reset mid-stream with three beats in flight
    i_cmd      = ident_cmd();
    i_cmd_load = 1'b1;
    i_valid    = 8'hFF;
    i_data_bus = {8{32'h77}};
    tick();
    i_cmd_load = 1'b0;
    tick();
    tick();
    rst        = 1'b0;
    i_cmd_load = 1'b1;
    i_err_clr  = 1'b1;
    tick();
    check_eq("mrst_valid", o_valid, 0);
    check_eq("mrst_data", o_data_bus, 0);
    rst       = 1'b1;
    i_err_clr = 1'b0;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("mrst_no_ghost", o_valid, 0);
    end
    // Load during reset must not have taken effect.
    i_valid    = 8'hFF;
    i_data_bus = {8{32'h5A}};
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    check_eq("mrst_cmd_cleared", o_valid, 0);
    i_cmd      = ident_cmd();
    i_cmd_load = 1'b1;
    i_valid    = 8'hFF;
    i_data_bus = {8{32'hC3}};
    tick();
    idle_inputs();
    tick();
    tick();
    check_eq("post_rst_early", o_valid, 0);
    tick();
    check_eq("post_rst_valid", o_valid, 8'hFF);
    check_eq("post_rst_data", o_data_bus, {8{32'hC3}});

    // Odd parameters: identity then input 4 onto output 0, latency 2
    i_valid_odd    = 5'h1F;
    for (int i = 0; i < 5; i++) i_data_odd[i*7 +: 7] = 7'(7'h50 + i);
    i_cmd_odd      = 15'h0111;
    i_cmd_load_odd = 1'b1;
    tick();
    check_eq("odd_early", o_valid_odd, 0);
    i_cmd_odd      = 15'h1110;
    tick();
    i_cmd_load_odd = 1'b0;
    i_valid_odd    = '0;
    check_eq("odd_ident_valid", o_valid_odd, 3'h7);
    check_eq("odd_ident_data", o_data_odd, {7'h52, 7'h51, 7'h50});
    tick();
    check_eq("odd_remap_valid", o_valid_odd, 3'h7);
    check_eq("odd_remap_data", o_data_odd, {7'h52, 7'h51, 7'h54});
    check_eq("odd_conflict", o_conflict_odd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
